// File: rtl/xdma_read_data_path_if.sv
// Handshake bundle for the xDMA read data path.
//   Descriptor : r_desc_len_i, r_desc_valid_i -> r_desc_ready_o
//   AXI R      : r_data_i, r_resp_i, r_last_i, r_valid_i -> r_ready_o
//   Output     : rsp_data_o, rsp_last_o, rsp_valid_o <- rsp_ready_i
// Suffixes are from the data path's point of view. The data path binds to the
// slave modport; whatever feeds it and drains it binds to the master modport.
interface xdma_read_data_path_if #(
  parameter int unsigned DataWidth = 512,
  parameter int unsigned LenWidth  = 8
) ();
  logic [LenWidth-1:0]  r_desc_len_i;
  logic                 r_desc_valid_i;
  logic                 r_desc_ready_o;
  logic [DataWidth-1:0] r_data_i;
  logic [1:0]           r_resp_i;
  logic                 r_last_i;
  logic                 r_valid_i;
  logic                 r_ready_o;
  logic [DataWidth-1:0] rsp_data_o;
  logic                 rsp_last_o;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;

  modport slave (
    input  r_desc_len_i, r_desc_valid_i, r_data_i, r_resp_i, r_last_i, r_valid_i,
           rsp_ready_i,
    output r_desc_ready_o, r_ready_o, rsp_data_o, rsp_last_o, rsp_valid_o
  );

  modport master (
    output r_desc_len_i, r_desc_valid_i, r_data_i, r_resp_i, r_last_i, r_valid_i,
           rsp_ready_i,
    input  r_desc_ready_o, r_ready_o, rsp_data_o, rsp_last_o, rsp_valid_o
  );
endinterface

// File: rtl/xdma_read_data_path.sv
// Receive-side xDMA data path. Takes a beat-count descriptor, consumes the
// matching AXI R burst and forwards each beat through a one-entry output
// register. RLAST position and RRESP are checked; one done pulse with sticky
// error flags is reported per burst.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : descriptor, AXI R and output stream handshakes (slave side)
//   done_o        : 1-cycle pulse once the burst is received and drained
//   err_o         : [0] RLAST mismatch, [1] non-OKAY RRESP; valid with done_o
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a descriptor, R channel closed
// BUSY   | accepting R beats until the descriptor count is exhausted
// DRAIN  | last beat taken, waiting for the output register to empty
// FINISH | single cycle presenting done_o and err_o
module xdma_read_data_path #(
  parameter int unsigned DataWidth = 512,
  parameter int unsigned LenWidth  = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  xdma_read_data_path_if.slave           bus,
  output logic                           done_o,
  output logic [1:0]                     err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [LenWidth-1:0]  cnt_q, cnt_d;
  logic [1:0]           err_q, err_d;
  logic                 out_valid_q, out_valid_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;

  logic desc_ready;
  logic r_ready;
  logic r_hs;
  logic out_pop;
  logic cnt_zero;

  assign out_pop  = out_valid_q && bus.rsp_ready_i;
  assign cnt_zero = (cnt_q == '0);
  assign r_hs     = r_ready && bus.r_valid_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    desc_ready  = 1'b0;
    r_ready     = 1'b0;
    done_o      = 1'b0;
    err_o       = 2'b00;

    // Emptying returns data/last to zero; a load below overrides this,
    // which is what gives pass-through when load and drain coincide.
    if (out_pop) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        desc_ready = 1'b1;
        if (bus.r_desc_valid_i) begin
          cnt_d   = bus.r_desc_len_i;
          err_d   = 2'b00;
          state_d = BUSY;
        end
      end
      BUSY: begin
        r_ready = !out_valid_q || bus.rsp_ready_i;
        if (r_hs) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.r_data_i;
          out_last_d  = cnt_zero;
          if (bus.r_last_i != cnt_zero) err_d[0] = 1'b1;
          if (bus.r_resp_i != 2'b00)    err_d[1] = 1'b1;
          // The descriptor count alone ends the burst; RLAST is only checked.
          if (!cnt_zero) cnt_d = cnt_q - LenWidth'(1);
          else           state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid_q || out_pop) state_d = FINISH;
      end
      FINISH: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 2'b00;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.r_desc_ready_o = desc_ready;
  assign bus.r_ready_o      = r_ready;
  assign bus.rsp_valid_o    = out_valid_q;
  assign bus.rsp_data_o     = out_data_q;
  assign bus.rsp_last_o     = out_last_q;

endmodule
